// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU external bus controller.
package cpu_bus_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [1:0] REG_SRAM = 2'd0;
  localparam logic [1:0] REG_IO   = 2'd1;
  localparam logic [1:0] REG_EXT  = 2'd2;
  localparam logic [1:0] REG_ROM  = 2'd3;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hFFFF_FFFF;

  function automatic logic [3:0] region_onehot(
    input logic [1:0] r
  );
    logic [3:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpu_bus_region_dec.sv
// Address-region decode: one-hot chip select and wait-mode select.
module cpu_bus_region_dec
  import cpu_bus_pkg::*;
(
  input  logic [1:0] i_region,
  output logic [3:0] o_cs,
  output logic       o_fixed
);

  always_comb begin
    o_cs    = region_onehot(i_region);
    o_fixed = 1'b0;
    unique case (i_region)
      REG_SRAM: o_fixed = 1'b1;
      REG_IO,
      REG_EXT,
      REG_ROM:  o_fixed = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU strobe bus to device req/ack bridge with wait states and timeout.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            WAIT0    = 2,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DFLT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_bus_clk,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_ready,
  output logic          o_dev_req,
  output logic          o_dev_we,
  output logic [AW-1:0] o_dev_addr,
  output logic [DW-1:0] o_dev_wdata,
  output logic [3:0]    o_dev_cs,
  input  logic          i_dev_ack,
  input  logic [DW-1:0] i_dev_rdata,
  output logic          o_bus_err,
  output logic          o_overrun,
  input  logic          i_err_clr
);

  localparam int CMAX = (WAIT0 > TIMEOUT) ? WAIT0 : TIMEOUT;
  localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_hist;
  logic [CW-1:0]   r_cnt;
  logic            r_req;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [3:0]      r_cs;
  logic [DW-1:0]   r_rdata;
  logic            r_ready;
  logic            r_err;
  logic            r_ovr;

  logic            w_edge;
  logic            w_start;
  logic            w_done;
  logic            w_tmo;
  logic            w_cnt_zero;
  logic            w_ovr_set;
  logic [3:0]      w_cs;
  logic            w_fixed;

  cpu_bus_region_dec u_dec (
    .i_region (i_cpu_addr[AW-1:AW-2]),
    .o_cs     (w_cs),
    .o_fixed  (w_fixed)
  );

  assign w_edge     = i_cpu_bus_clk & ~r_hist;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_ovr_set  = w_edge & (r_state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Region 0 completes on count alone; others on ack, else timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_start     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cs[REG_SRAM]) begin
          w_done = w_cnt_zero;
        end else if (i_dev_ack) begin
          w_done = 1'b1;
        end else if (w_cnt_zero) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
        end
        if (w_done) w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= w_fixed ? CW'(WAIT0) : CW'(TIMEOUT);
    end else if (r_state == ACCESS && !w_done) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hist  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cs    <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      r_hist  <= i_cpu_bus_clk;
      r_ready <= w_done;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= i_cpu_we;
        r_addr  <= i_cpu_addr;
        r_wdata <= i_cpu_wdata;
        r_cs    <= w_cs;
      end else if (w_done) begin
        r_req <= 1'b0;
        r_cs  <= '0;
      end
      if (w_done && !r_we) begin
        r_rdata <= w_tmo ? ERR_DATA : i_dev_rdata;
      end
    end
  end

  // Sticky flags: a same-cycle set beats the clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_tmo)          r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (i_err_clr) r_ovr <= 1'b0;
    end
  end

  assign o_cpu_rdata = r_rdata;
  assign o_cpu_ready = r_ready;
  assign o_dev_req   = r_req;
  assign o_dev_we    = r_we;
  assign o_dev_addr  = r_addr;
  assign o_dev_wdata = r_wdata;
  assign o_dev_cs    = r_cs;
  assign o_bus_err   = r_err;
  assign o_overrun   = r_ovr;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: vector table plus corner sequences.
module tb_cpu_bus_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_cpu_bus_clk;
  logic        i_cpu_we;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_wdata;
  logic [31:0] o_cpu_rdata;
  logic        o_cpu_ready;
  logic        o_dev_req;
  logic        o_dev_we;
  logic [31:0] o_dev_addr;
  logic [31:0] o_dev_wdata;
  logic [3:0]  o_dev_cs;
  logic        i_dev_ack;
  logic [31:0] i_dev_rdata;
  logic        o_bus_err;
  logic        o_overrun;
  logic        i_err_clr;

  always #5 clk = ~clk;

  cpu_bus_ctrl #(
    .AW       (32),
    .DW       (32),
    .WAIT0    (2),
    .TIMEOUT  (TMO),
    .ERR_DATA (32'hFFFF_FFFF)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_cpu_bus_clk (i_cpu_bus_clk),
    .i_cpu_we      (i_cpu_we),
    .i_cpu_addr    (i_cpu_addr),
    .i_cpu_wdata   (i_cpu_wdata),
    .o_cpu_rdata   (o_cpu_rdata),
    .o_cpu_ready   (o_cpu_ready),
    .o_dev_req     (o_dev_req),
    .o_dev_we      (o_dev_we),
    .o_dev_addr    (o_dev_addr),
    .o_dev_wdata   (o_dev_wdata),
    .o_dev_cs      (o_dev_cs),
    .i_dev_ack     (i_dev_ack),
    .i_dev_rdata   (i_dev_rdata),
    .o_bus_err     (o_bus_err),
    .o_overrun     (o_overrun),
    .i_err_clr     (i_err_clr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] drdata;
    int          ack_dly;
    logic        tmo;
    logic [3:0]  exp_cs;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int          nvec = 0;
  int          nmis = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;
  vec_t        vt[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic we, input logic tmo,
                               input logic [31:0] d);
    if (!we) m_rdata = tmo ? 32'hFFFF_FFFF : d;
    if (tmo) m_err = 1'b1;
    sb.push_back('{m_rdata, m_err});
  endfunction

  always @(negedge clk) begin
    if (i_rst && o_cpu_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL spurious_ready: got ready with no pending txn");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rdata", o_cpu_rdata, mon_e.rdata);
        chk("sb_err", o_bus_err, mon_e.err);
      end
    end
  end

  task automatic wait_ready(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (o_cpu_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    lat = -1;
    @(negedge clk);
    i_cpu_bus_clk = 1'b1;
    i_cpu_we      = v.we;
    i_cpu_addr    = v.addr;
    i_cpu_wdata   = v.wdata;
    i_dev_rdata   = v.drdata;
    push(v.we, v.tmo, v.drdata);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_cpu_bus_clk = 1'b0;
        chk("req", o_dev_req, 1);
        chk("cs", o_dev_cs, v.exp_cs);
        chk("dev_we", o_dev_we, v.we);
        chk("dev_addr", o_dev_addr, v.addr);
        chk("dev_wdata", o_dev_wdata, v.wdata);
      end
      if (o_cpu_ready) begin
        lat = k;
        break;
      end
      if (k == v.ack_dly) i_dev_ack = 1'b1;
    end
    i_dev_ack = 1'b0;
    chk("latency", lat, v.exp_lat);
    chk("req_done", o_dev_req, 0);
    chk("cs_done", o_dev_cs, 0);
    chk("addr_hold", o_dev_addr, v.addr);
    @(negedge clk);
    chk("ready_pulse", o_cpu_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    vt[0] = '{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678,
              1, 1'b0, 4'b0001, 4};
    vt[1] = '{1'b1, 32'h4000_0010, 32'hA5A5_A5A5, 32'h7777_7777,
              5, 1'b0, 4'b0010, 6};
    vt[2] = '{1'b0, 32'h4000_0044, 32'h0,         32'h0BAD_F00D,
              5, 1'b0, 4'b0010, 6};
    vt[3] = '{1'b0, 32'hC000_0004, 32'h0,         32'hCAFE_0001,
              1, 1'b0, 4'b1000, 2};
    vt[4] = '{1'b0, 32'h8000_0020, 32'h0,         32'h5A5A_0000,
              0, 1'b1, 4'b0100, 6};
    vt[5] = '{1'b1, 32'h0000_0200, 32'h1111_2222, 32'h3333_4444,
              0, 1'b0, 4'b0001, 4};
    vt[6] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         32'h0000_00AA,
              0, 1'b0, 4'b0001, 4};
    vt[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hBEEF_0007,
              3, 1'b0, 4'b1000, 4};

    i_rst         = 1'b0;
    i_cpu_bus_clk = 1'b0;
    i_cpu_we      = 1'b0;
    i_cpu_addr    = 32'h0;
    i_cpu_wdata   = 32'h0;
    i_dev_ack     = 1'b0;
    i_dev_rdata   = 32'h0;
    i_err_clr     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", o_dev_req, 0);
    chk("rst_ready", o_cpu_ready, 0);
    chk("rst_cs", o_dev_cs, 0);
    chk("rst_rdata", o_cpu_rdata, 0);
    chk("rst_flags", {o_bus_err, o_overrun}, 0);
    i_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    @(negedge clk);
    chk("err_sticky", o_bus_err, 1);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    m_err     = 1'b0;
    chk("err_clr", o_bus_err, 0);

    // Overrun: second edge two cycles into a region-1 access
    @(negedge clk);
    i_cpu_bus_clk = 1'b1;
    i_cpu_we      = 1'b0;
    i_cpu_addr    = 32'h4000_0080;
    i_dev_rdata   = 32'h5555_AAAA;
    push(1'b0, 1'b0, 32'h5555_AAAA);
    @(negedge clk);
    i_cpu_bus_clk = 1'b0;
    chk("ovr_pre", o_overrun, 0);
    @(negedge clk);
    i_cpu_bus_clk = 1'b1;
    i_cpu_addr    = 32'h8000_0000;
    @(negedge clk);
    i_cpu_bus_clk = 1'b0;
    chk("overrun", o_overrun, 1);
    chk("ovr_addr", o_dev_addr, 32'h4000_0080);
    chk("ovr_cs", o_dev_cs, 4'b0010);
    i_dev_ack = 1'b1;
    @(negedge clk);
    chk("ovr_ready", o_cpu_ready, 1);
    i_dev_ack = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_cpu_ready) pulses++;
    end
    chk("ovr_single", pulses, 0);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    chk("ovr_clr", o_overrun, 0);

    // Back-to-back: new edge lands in the ready cycle
    @(negedge clk);
    i_cpu_bus_clk = 1'b1;
    i_cpu_addr    = 32'h0000_1000;
    i_dev_rdata   = 32'h1010_1010;
    push(1'b0, 1'b0, 32'h1010_1010);
    @(negedge clk);
    i_cpu_bus_clk = 1'b0;
    wait_ready(20, n);
    chk("b2b_lat1", n, 3);
    i_cpu_bus_clk = 1'b1;
    i_cpu_addr    = 32'h0000_2000;
    i_dev_rdata   = 32'h2020_2020;
    push(1'b0, 1'b0, 32'h2020_2020);
    @(negedge clk);
    i_cpu_bus_clk = 1'b0;
    chk("b2b_req", o_dev_req, 1);
    chk("b2b_addr", o_dev_addr, 32'h0000_2000);
    wait_ready(20, n);
    chk("b2b_lat2", n, 3);

    // Reset in the middle of a region-3 access
    @(negedge clk);
    i_cpu_bus_clk = 1'b1;
    i_cpu_addr    = 32'hC000_0100;
    @(negedge clk);
    i_cpu_bus_clk = 1'b0;
    chk("mid_req", o_dev_req, 1);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("arst_req", o_dev_req, 0);
    chk("arst_ready", o_cpu_ready, 0);
    chk("arst_cs", o_dev_cs, 0);
    chk("arst_rdata", o_cpu_rdata, 0);
    m_rdata = 32'h0;
    m_err   = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("arst_noready", o_cpu_ready, 0);
    run_vec('{1'b0, 32'h4000_0300, 32'h0, 32'h600D_0001,
              2, 1'b0, 4'b0010, 3});

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
